// File: rtl/mem_bus_bridge.sv
// Load/store bridge from the CPU memory stage to data RAM and the MMIO window.
// Decodes the target, builds byte enables and replicated write data, and extends read data.
module mem_bus_bridge #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        busy,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        io_we,
    output logic [3:0]  io_be,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam int unsigned CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(RAM_LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q;
    logic          wr_q, sext_q, mis_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;

    logic          req_mis;
    logic          is_io;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;

    // Fault decision uses the live request so a misaligned access skips ACCESS entirely.
    assign req_mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign is_io   = (addr_q[31:10] == IO_BASE[31:10]);

    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        case (size_q)
            2'b00:   wdata_rep = {4{wdata_q[7:0]}};
            2'b01:   wdata_rep = {2{wdata_q[15:0]}};
            default: wdata_rep = wdata_q;
        endcase
    end

    // RAM data sits in its byte lane; MMIO registers are right-justified.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic        lane_shift,
                                                input logic [1:0]  sz,
                                                input logic        sx,
                                                input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        b = lane_shift ? word[{a, 3'b000} +: 8] : word[7:0];
        h = lane_shift ? word[{a[1], 4'b0000} +: 16] : word[15:0];
        case (sz)
            2'b00:   load_extend = {{24{sx & b[7]}}, b};
            2'b01:   load_extend = {{16{sx & h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        rdata     = '0;
        misalign  = 1'b0;
        busy      = (state_q != S_IDLE);
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        io_we     = 1'b0;
        io_be     = '0;
        io_addr   = '0;
        io_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = req_mis ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (is_io) begin
                    io_addr  = addr_q;
                    io_we    = wr_q;
                    io_be    = be;
                    io_wdata = wdata_rep;
                end else begin
                    ram_en    = 1'b1;
                    ram_we    = wr_q;
                    ram_be    = be;
                    ram_addr  = addr_q;
                    ram_wdata = wdata_rep;
                end
                state_d = (!wr_q && !is_io) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done     = 1'b1;
                rdata    = rdata_q;
                misalign = mis_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= 1'b0;
            sext_q     <= 1'b0;
            mis_q      <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        wr_q       <= wr;
                        sext_q     <= sext;
                        mis_q      <= req_mis;
                        size_q     <= size;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        rdata_q    <= '0;
                        wait_cnt_q <= '0;
                    end
                end
                S_ACCESS: begin
                    if (!wr_q && is_io) begin
                        rdata_q <= load_extend(io_rdata, 1'b0, size_q, sext_q, addr_q[1:0]);
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        rdata_q <= load_extend(ram_rdata, 1'b1, size_q, sext_q, addr_q[1:0]);
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
